// File: rtl/ooo_pkg.sv
// ---------------------------------------------------------------------------
// ooo_pkg
// Types and sizes that the rename stage, the reorder buffer and the register
// file agree on.
//   ROB_DEPTH : number of reorder buffer entries (power of two)
// TAG_W     : width of a ROB location tag, log2(ROB_DEPTH)
// DATA_W    : result / register data width
//   AREG_W    : architectural register index width
//   rob_tag_t : ROB location tag
//   rob_entry_t : per-entry state {valid, done, has_dest, dest, data}
// ---------------------------------------------------------------------------
package ooo_pkg;

   localparam int ROB_DEPTH = 64;
   localparam int TAG_W     = 6;
   localparam int DATA_W    = 16;
   localparam int AREG_W    = 3;

   typedef logic [TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_dest;
      logic [AREG_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } rob_entry_t;

   localparam rob_entry_t ENTRY_CLR = '{valid:    1'b0,
                                        done:     1'b0,
                                        has_dest: 1'b0,
                                        dest:     {AREG_W{1'b0}},
                                        data:     {DATA_W{1'b0}}};

endpackage

// File: rtl/rob_retire_sel.sv
// ---------------------------------------------------------------------------
// rob_retire_sel
// Picks how many entries leave the ROB this cycle. Retirement is strictly
// in order, so slot 1 can only fire behind a firing slot 0.
//   head_valid_i / head_done_i : flags of entry[head]
//   next_valid_i / next_done_i : flags of entry[head+1]
//   fire0_o / fire1_o          : retire slot 0 / slot 1
//   retire_cnt_o               : number of entries retired (0..2)
// ---------------------------------------------------------------------------
module rob_retire_sel
(
   input  logic       head_valid_i,
   input  logic       head_done_i,
   input  logic       next_valid_i,
   input  logic       next_done_i,
   output logic       fire0_o,
   output logic       fire1_o,
   output logic [1:0] retire_cnt_o
);

   // In-order two-wide retire selection.
   always_comb begin
      fire0_o      = head_valid_i & head_done_i;
      fire1_o      = fire0_o & next_valid_i & next_done_i;
      retire_cnt_o = {1'b0, fire0_o} + {1'b0, fire1_o};
   end

endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular ROB: allocates up to 4 tags per cycle, captures results from two
// writeback buses and retires up to two completed entries per cycle in
// program order, driving the architectural register file write ports.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous squash of every entry
//   alloc_count           : 0..4 lanes to allocate (A.. contiguous)
//   alloc_wenX/alloc_destX: per-lane destination info (X = A..D)
//   alloc_ready           : at least 4 free entries (current count only)
//   alloc_locX            : tag handed to lane X (tail + lane index)
//   wbN_valid/tag/data    : writeback buses N = 0,1 (wb0 wins on a tie)
//   commit_validN/locN    : registered retire slot N (0 = oldest)
//   wenN/waddrN/wdataN    : registered regfile write port N
// ---------------------------------------------------------------------------
module reorder_buffer
   import ooo_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [2:0]        alloc_count,
   input  logic              alloc_wenA,
   input  logic              alloc_wenB,
   input  logic              alloc_wenC,
   input  logic              alloc_wenD,
   input  logic [AREG_W-1:0] alloc_destA,
   input  logic [AREG_W-1:0] alloc_destB,
   input  logic [AREG_W-1:0] alloc_destC,
   input  logic [AREG_W-1:0] alloc_destD,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_locA,
   output logic [TAG_W-1:0]  alloc_locB,
   output logic [TAG_W-1:0]  alloc_locC,
   output logic [TAG_W-1:0]  alloc_locD,
   input  logic              wb0_valid,
   input  logic [TAG_W-1:0]  wb0_tag,
   input  logic [DATA_W-1:0] wb0_data,
   input  logic              wb1_valid,
   input  logic [TAG_W-1:0]  wb1_tag,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              commit_valid0,
   output logic [TAG_W-1:0]  commit_loc0,
   output logic              wen0,
   output logic [AREG_W-1:0] waddr0,
   output logic [DATA_W-1:0] wdata0,
   output logic              commit_valid1,
   output logic [TAG_W-1:0]  commit_loc1,
   output logic              wen1,
   output logic [AREG_W-1:0] waddr1,
   output logic [DATA_W-1:0] wdata1
);

   localparam int             LANES       = 4;
   localparam logic [TAG_W:0] ALLOC_LIMIT = (TAG_W+1)'(ROB_DEPTH - LANES);

   rob_entry_t        rob_q [ROB_DEPTH];
   rob_entry_t        rob_d [ROB_DEPTH];
   rob_tag_t          head_q, head_d;
   rob_tag_t          tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;

   logic              lane_wen_s  [LANES];
   logic [AREG_W-1:0] lane_dest_s [LANES];
   logic [2:0]        alloc_n_s;
   logic [2:0]        alloc_take_s;
   rob_tag_t          head1_s;
   logic              fire0_s, fire1_s;
   logic [1:0]        retire_cnt_s;
   logic              wb0_hit_s, wb1_hit_s;

   logic              commit_valid0_q, commit_valid1_q;
   rob_tag_t          commit_loc0_q, commit_loc1_q;
   logic              wen0_q, wen1_q;
   logic [AREG_W-1:0] waddr0_q, waddr1_q;
   logic [DATA_W-1:0] wdata0_q, wdata1_q;

   // Gather the four allocation lanes into indexable arrays.
   always_comb begin
      lane_wen_s[0]  = alloc_wenA;
      lane_wen_s[1]  = alloc_wenB;
      lane_wen_s[2]  = alloc_wenC;
      lane_wen_s[3]  = alloc_wenD;
      lane_dest_s[0] = alloc_destA;
      lane_dest_s[1] = alloc_destB;
      lane_dest_s[2] = alloc_destC;
      lane_dest_s[3] = alloc_destD;
   end

   // Allocation handshake: space is judged on the current count only.
   always_comb begin
      alloc_ready = (count_q <= ALLOC_LIMIT);
      alloc_locA  = tail_q;
      alloc_locB  = tail_q + rob_tag_t'(1);
      alloc_locC  = tail_q + rob_tag_t'(2);
      alloc_locD  = tail_q + rob_tag_t'(3);
      // An out-of-range request is treated as a full 4-wide group.
      alloc_n_s    = (alloc_count > 3'd4) ? 3'd4 : alloc_count;
      alloc_take_s = (!flush && alloc_ready) ? alloc_n_s : 3'd0;
      head1_s      = head_q + rob_tag_t'(1);
      wb0_hit_s    = wb0_valid & rob_q[wb0_tag].valid;
      wb1_hit_s    = wb1_valid & rob_q[wb1_tag].valid;
   end

   rob_retire_sel u_retire_sel (
      .head_valid_i (rob_q[head_q].valid),
      .head_done_i  (rob_q[head_q].done),
      .next_valid_i (rob_q[head1_s].valid),
      .next_done_i  (rob_q[head1_s].done),
      .fire0_o      (fire0_s),
      .fire1_o      (fire1_s),
      .retire_cnt_o (retire_cnt_s)
   );

   // Next-state of entry array and pointers (flush overrides everything).
   always_comb begin
      rob_d   = rob_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            rob_d[i].valid = 1'b0;
            rob_d[i].done  = 1'b0;
         end
         head_d  = rob_tag_t'(0);
         tail_d  = rob_tag_t'(0);
         count_d = (TAG_W+1)'(0);
      end else begin
         // wb1 is applied first so wb0 overwrites it on a shared tag.
         rob_d[wb1_tag].done = rob_d[wb1_tag].done | wb1_hit_s;
         rob_d[wb1_tag].data = wb1_hit_s ? wb1_data : rob_d[wb1_tag].data;
         rob_d[wb0_tag].done = rob_d[wb0_tag].done | wb0_hit_s;
         rob_d[wb0_tag].data = wb0_hit_s ? wb0_data : rob_d[wb0_tag].data;
         // Retired entries are released.
         rob_d[head_q].valid  = rob_d[head_q].valid  & ~fire0_s;
         rob_d[head_q].done   = rob_d[head_q].done   & ~fire0_s;
         rob_d[head1_s].valid = rob_d[head1_s].valid & ~fire1_s;
         rob_d[head1_s].done  = rob_d[head1_s].done  & ~fire1_s;
         // Allocated slots are always invalid today, so no retire overlap.
         for (int lane = 0; lane < LANES; lane++) begin
            rob_d[tail_q + rob_tag_t'(lane)] = (3'(lane) < alloc_take_s) ?
               rob_entry_t'{valid:    1'b1,
                            done:     1'b0,
                            has_dest: lane_wen_s[lane],
                            dest:     lane_dest_s[lane],
                            data:     {DATA_W{1'b0}}} :
               rob_d[tail_q + rob_tag_t'(lane)];
         end
         head_d  = head_q + rob_tag_t'(retire_cnt_s);
         tail_d  = tail_q + rob_tag_t'(alloc_take_s);
         count_d = count_q + (TAG_W+1)'(alloc_take_s) - (TAG_W+1)'(retire_cnt_s);
      end
   end

   // Entry array and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            rob_q[i] <= ENTRY_CLR;
         end
         head_q  <= rob_tag_t'(0);
         tail_q  <= rob_tag_t'(0);
         count_q <= (TAG_W+1)'(0);
      end else begin
         rob_q   <= rob_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Registered retire ports; every field is zero when its slot is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_valid0_q <= 1'b0;
         commit_loc0_q   <= rob_tag_t'(0);
         wen0_q          <= 1'b0;
         waddr0_q        <= {AREG_W{1'b0}};
         wdata0_q        <= {DATA_W{1'b0}};
         commit_valid1_q <= 1'b0;
         commit_loc1_q   <= rob_tag_t'(0);
         wen1_q          <= 1'b0;
         waddr1_q        <= {AREG_W{1'b0}};
         wdata1_q        <= {DATA_W{1'b0}};
      end else if (flush) begin
         commit_valid0_q <= 1'b0;
         commit_loc0_q   <= rob_tag_t'(0);
         wen0_q          <= 1'b0;
         waddr0_q        <= {AREG_W{1'b0}};
         wdata0_q        <= {DATA_W{1'b0}};
         commit_valid1_q <= 1'b0;
         commit_loc1_q   <= rob_tag_t'(0);
         wen1_q          <= 1'b0;
         waddr1_q        <= {AREG_W{1'b0}};
         wdata1_q        <= {DATA_W{1'b0}};
      end else begin
         commit_valid0_q <= fire0_s;
         commit_loc0_q   <= fire0_s ? head_q : rob_tag_t'(0);
         wen0_q          <= fire0_s & rob_q[head_q].has_dest;
         waddr0_q        <= fire0_s ? rob_q[head_q].dest : {AREG_W{1'b0}};
         wdata0_q        <= fire0_s ? rob_q[head_q].data : {DATA_W{1'b0}};
         commit_valid1_q <= fire1_s;
         commit_loc1_q   <= fire1_s ? head1_s : rob_tag_t'(0);
         wen1_q          <= fire1_s & rob_q[head1_s].has_dest;
         waddr1_q        <= fire1_s ? rob_q[head1_s].dest : {AREG_W{1'b0}};
         wdata1_q        <= fire1_s ? rob_q[head1_s].data : {DATA_W{1'b0}};
      end
   end

   assign commit_valid0 = commit_valid0_q;
   assign commit_loc0   = commit_loc0_q;
   assign wen0          = wen0_q;
   assign waddr0        = waddr0_q;
   assign wdata0        = wdata0_q;
   assign commit_valid1 = commit_valid1_q;
   assign commit_loc1   = commit_loc1_q;
   assign wen1          = wen1_q;
   assign waddr1        = waddr1_q;
   assign wdata1        = wdata1_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
// Directed scenarios followed by randomized traffic. A program-order queue
// model predicts allocation tags, readiness and the retire stream; expected
// retirements are queued and a negedge monitor compares them to the DUT.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
   import ooo_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic [2:0]        alloc_count;
   logic              lwen  [4];
   logic [AREG_W-1:0] ldest [4];
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_locA, alloc_locB, alloc_locC, alloc_locD;
   logic              wb0_valid, wb1_valid;
   logic [TAG_W-1:0]  wb0_tag, wb1_tag;
   logic [DATA_W-1:0] wb0_data, wb1_data;
   logic              commit_valid0, commit_valid1;
   logic [TAG_W-1:0]  commit_loc0, commit_loc1;
   logic              wen0, wen1;
   logic [AREG_W-1:0] waddr0, waddr1;
   logic [DATA_W-1:0] wdata0, wdata1;

   reorder_buffer dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_count(alloc_count),
      .alloc_wenA(lwen[0]), .alloc_wenB(lwen[1]), .alloc_wenC(lwen[2]), .alloc_wenD(lwen[3]),
      .alloc_destA(ldest[0]), .alloc_destB(ldest[1]), .alloc_destC(ldest[2]), .alloc_destD(ldest[3]),
      .alloc_ready(alloc_ready),
      .alloc_locA(alloc_locA), .alloc_locB(alloc_locB), .alloc_locC(alloc_locC), .alloc_locD(alloc_locD),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
      .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
      .commit_valid0(commit_valid0), .commit_loc0(commit_loc0), .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
      .commit_valid1(commit_valid1), .commit_loc1(commit_loc1), .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: live instructions in program order.
   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic              hd;
      logic [AREG_W-1:0] dest;
      logic              done;
      logic [DATA_W-1:0] data;
   } ment_t;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic              wen;
      logic [AREG_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } exp_t;

   ment_t            mq[$];
   exp_t             expq[$];
   logic [TAG_W-1:0] mtail;
   logic [DATA_W-1:0] rf [8];
   int               n_tests = 0;
   int               n_fail  = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      flush       = 1'b0;
      alloc_count = 3'd0;
      for (int k = 0; k < 4; k++) begin
         lwen[k]  = 1'b0;
         ldest[k] = 3'd0;
      end
      wb0_valid = 1'b0; wb0_tag = 6'd0; wb0_data = 16'd0;
      wb1_valid = 1'b0; wb1_tag = 6'd0; wb1_data = 16'd0;
   endtask

   task automatic set_alloc_rand(int n);
      alloc_count = 3'(n);
      for (int k = 0; k < 4; k++) begin
         lwen[k]  = 1'($urandom_range(0, 1));
         ldest[k] = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic apply_wb(logic [TAG_W-1:0] t, logic [DATA_W-1:0] d);
      foreach (mq[i]) begin
         if (mq[i].tag == t) begin
            mq[i].done = 1'b1;
            mq[i].data = d;
         end
      end
   endtask

   // One clock edge of the model, using the inputs presented this cycle.
   task automatic model_edge();
      int  sz;
      bool_blk: begin end
      sz = mq.size();
      if (flush) begin
         mq.delete();
         mtail = 6'd0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (mq.size() > 0 && mq[0].done && (k == 0 || expq.size() > 0)) begin
               expq.push_back('{tag: mq[0].tag, wen: mq[0].hd, waddr: mq[0].dest, wdata: mq[0].data});
               void'(mq.pop_front());
            end else begin
               k = 2;
            end
         end
         if (wb1_valid) apply_wb(wb1_tag, wb1_data);
         if (wb0_valid) apply_wb(wb0_tag, wb0_data);
         if (alloc_count != 3'd0 && sz <= ROB_DEPTH - 4) begin
            for (int l = 0; l < int'(alloc_count); l++) begin
               mq.push_back('{tag: mtail + 6'(l), hd: lwen[l], dest: ldest[l], done: 1'b0, data: 16'd0});
            end
            mtail = mtail + 6'(alloc_count);
         end
      end
   endtask

   task automatic tick();
      logic [TAG_W-1:0] e;
      #1;
      check("alloc_ready", 32'(alloc_ready), 32'(mq.size() <= ROB_DEPTH - 4));
      check("alloc_locA", 32'(alloc_locA), 32'(mtail));
      e = mtail + 6'd1; check("alloc_locB", 32'(alloc_locB), 32'(e));
      e = mtail + 6'd2; check("alloc_locC", 32'(alloc_locC), 32'(e));
      e = mtail + 6'd3; check("alloc_locD", 32'(alloc_locD), 32'(e));
      @(posedge clk);
      model_edge();
      #1;
      idle_inputs();
   endtask

   task automatic drain(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Complete every outstanding instruction, two writebacks per cycle.
   task automatic complete_all();
      for (int it = 0; it < 80; it++) begin
         int picked;
         picked = 0;
         foreach (mq[i]) begin
            if (!mq[i].done && picked < 2) begin
               if (picked == 0) begin
                  wb0_valid = 1'b1; wb0_tag = mq[i].tag; wb0_data = 16'($urandom);
               end else begin
                  wb1_valid = 1'b1; wb1_tag = mq[i].tag; wb1_data = 16'($urandom);
               end
               picked++;
            end
         end
         if (picked == 0) it = 80;
         else tick();
      end
   endtask

   task automatic goto_tail(logic [TAG_W-1:0] target);
      for (int it = 0; it < 40 && mtail != target; it++) begin
         logic [TAG_W-1:0] diff;
         diff = target - mtail;
         if (mq.size() > ROB_DEPTH - 4) begin
            complete_all();
            drain(3);
         end
         set_alloc_rand((diff >= 6'd4) ? 4 : int'(diff));
         tick();
      end
      complete_all();
      drain(3);
   endtask

   // Scoreboard monitor: pops expected retirements when the DUT presents them.
   task automatic pop_cmp(string s, logic [TAG_W-1:0] loc, logic w,
                          logic [AREG_W-1:0] a, logic [DATA_W-1:0] d);
      exp_t e;
      if (expq.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s_unexpected: got commit of tag %0d expected none", s, loc);
      end else begin
         e = expq.pop_front();
         check({s, "_loc"}, 32'(loc), 32'(e.tag));
         check({s, "_wen"}, 32'(w), 32'(e.wen));
         check({s, "_wdata"}, 32'(d), 32'(e.wdata));
         if (e.wen) check({s, "_waddr"}, 32'(a), 32'(e.waddr));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (commit_valid0) pop_cmp("slot0", commit_loc0, wen0, waddr0, wdata0);
         else check("slot0_idle_zero", {commit_loc0, wen0, waddr0, wdata0}, 32'd0);
         if (commit_valid1) begin
            check("slot1_without_slot0", 32'(commit_valid0), 32'd1);
            pop_cmp("slot1", commit_loc1, wen1, waddr1, wdata1);
         end else begin
            check("slot1_idle_zero", {commit_loc1, wen1, waddr1, wdata1}, 32'd0);
         end
         if (wen0) rf[waddr0] = wdata0;
         if (wen1) rf[waddr1] = wdata1;
         check("commit_latency", 32'(expq.size()), 32'd0);
         expq.delete();
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mtail = 6'd0;
      idle_inputs();
      for (int i = 0; i < 8; i++) rf[i] = 16'd0;
      #1;
      check("reset_outputs", {31'd0, commit_valid0 | commit_valid1 | wen0 | wen1}, 32'd0);
      check("reset_locD", 32'(alloc_locD), 32'd3);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic allocate and first retirement.
      alloc_count = 3'd4;
      for (int k = 0; k < 4; k++) begin lwen[k] = 1'b1; ldest[k] = 3'(k + 1); end
      tick();
      wb0_valid = 1'b1; wb0_tag = 6'd0; wb0_data = 16'h00AA;
      tick();
      tick();
      check("first_wen0", 32'(wen0), 32'd1);
      check("first_waddr0", 32'(waddr0), 32'd1);
      check("first_wdata0", 32'(wdata0), 32'h00AA);
      check("first_loc0", 32'(commit_loc0), 32'd0);
      complete_all();
      drain(3);

      // Out-of-order completion: tags 4..7.
      set_alloc_rand(4);
      tick();
      wb0_valid = 1'b1; wb0_tag = 6'd6; wb0_data = 16'h0066;
      tick();
      drain(2);
      check("ooo_no_retire", 32'(commit_valid0), 32'd0);
      wb0_valid = 1'b1; wb0_tag = 6'd5; wb0_data = 16'h0055;
      wb1_valid = 1'b1; wb1_tag = 6'd4; wb1_data = 16'h0044;
      tick();
      tick();
      check("ooo_pair_v0", 32'(commit_valid0), 32'd1);
      check("ooo_pair_loc0", 32'(commit_loc0), 32'd4);
      check("ooo_pair_v1", 32'(commit_valid1), 32'd1);
      check("ooo_pair_loc1", 32'(commit_loc1), 32'd5);
      tick();
      check("ooo_next_loc0", 32'(commit_loc0), 32'd6);
      check("ooo_next_v1", 32'(commit_valid1), 32'd0);
      complete_all();
      drain(3);

      // Same-destination pair retiring together (tags 8 and 9 -> r5).
      alloc_count = 3'd2;
      lwen[0] = 1'b1; ldest[0] = 3'd5; lwen[1] = 1'b1; ldest[1] = 3'd5;
      tick();
      wb0_valid = 1'b1; wb0_tag = 6'd8; wb0_data = 16'd1;
      wb1_valid = 1'b1; wb1_tag = 6'd9; wb1_data = 16'd2;
      tick();
      tick();
      check("samedest_wen_both", {30'd0, wen0, wen1}, 32'd3);
      @(negedge clk); #1;
      check("samedest_rf5", 32'(rf[5]), 32'd2);
      @(posedge clk); #1;
      drain(2);

      // Fill to 64 entries, then free space two at a time.
      for (int i = 0; i < 16; i++) begin set_alloc_rand(4); tick(); end
      #1;
      check("full_not_ready", 32'(alloc_ready), 32'd0);
      set_alloc_rand(4);
      tick();
      check("full_size_model", 32'(mq.size()), 32'd64);
      wb0_valid = 1'b1; wb0_tag = mq[0].tag; wb0_data = 16'h1111;
      wb1_valid = 1'b1; wb1_tag = mq[1].tag; wb1_data = 16'h2222;
      tick();
      tick();
      check("62_used_not_ready", 32'(alloc_ready), 32'd0);
      wb0_valid = 1'b1; wb0_tag = mq[0].tag; wb0_data = 16'h3333;
      wb1_valid = 1'b1; wb1_tag = mq[1].tag; wb1_data = 16'h4444;
      tick();
      tick();
      check("60_used_ready", 32'(alloc_ready), 32'd1);
      complete_all();
      drain(3);

      // Wrap: bring head/tail to 62, allocate across the boundary.
      goto_tail(6'd62);
      set_alloc_rand(4);
      #1;
      check("wrap_locC", 32'(alloc_locC), 32'd0);
      check("wrap_locD", 32'(alloc_locD), 32'd1);
      tick();
      complete_all();
      drain(3);

      // Flush with live entries, a selected retirement and a same-cycle wb.
      set_alloc_rand(4); tick();
      set_alloc_rand(4); tick();
      set_alloc_rand(2); tick();
      wb0_valid = 1'b1; wb0_tag = mq[0].tag; wb0_data = 16'hBEEF;
      wb1_valid = 1'b1; wb1_tag = mq[1].tag; wb1_data = 16'hCAFE;
      tick();
      flush = 1'b1;
      wb0_valid = 1'b1; wb0_tag = mq[2].tag; wb0_data = 16'hDEAD;
      tick();
      check("flush_outputs", {29'd0, commit_valid0, commit_valid1, wen0 | wen1}, 32'd0);
      check("flush_locA", 32'(alloc_locA), 32'd0);
      check("flush_ready", 32'(alloc_ready), 32'd1);
      drain(3);

      // Asynchronous reset while a retirement is on the outputs.
      set_alloc_rand(4); tick();
      wb0_valid = 1'b1; wb0_tag = mq[0].tag; wb0_data = 16'h7777;
      wb1_valid = 1'b1; wb1_tag = mq[1].tag; wb1_data = 16'h8888;
      tick();
      tick();
      check("pre_reset_commit", 32'(commit_valid0), 32'd1);
      #2;
      rst_n = 1'b0;
      mq.delete(); expq.delete(); mtail = 6'd0;
      #1;
      check("async_reset_outputs", {commit_loc0, wen0, waddr0, wdata0}, 32'd0);
      check("async_reset_v", {30'd0, commit_valid0, commit_valid1}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         set_alloc_rand($urandom_range(0, 4));
         if ($urandom_range(0, 149) == 0) flush = 1'b1;
         if (mq.size() > 0 && $urandom_range(0, 9) < 6) begin
            wb0_valid = 1'b1;
            wb0_tag   = mq[$urandom_range(0, mq.size() - 1)].tag;
            wb0_data  = 16'($urandom);
         end
         if (mq.size() > 0 && $urandom_range(0, 9) < 5) begin
            wb1_valid = 1'b1;
            wb1_tag   = ($urandom_range(0, 7) == 0) ? wb0_tag : mq[$urandom_range(0, mq.size() - 1)].tag;
            wb1_data  = 16'($urandom);
         end else if (mq.size() < ROB_DEPTH && $urandom_range(0, 9) == 0) begin
            wb1_valid = 1'b1;
            wb1_tag   = mtail;
            wb1_data  = 16'($urandom);
         end
         tick();
      end
      complete_all();
      drain(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
